// File: rtl/cache_pkg.sv
// Shared definitions for the cache's backing RAM server: default geometry,
// returned-block type and server FSM state encoding.
package cache_pkg;

  localparam int CACHE_RAM_ADDRESS_BITS = 10;
  localparam int CACHE_DATA_BITS        = 32;
  localparam int CACHE_BLOCK_BITS       = 2;
  localparam int CACHE_BLOCK_SIZE       = 2 ** CACHE_BLOCK_BITS;
  localparam int CACHE_LATENCY          = 3;

  // One cache line as returned by the server; element i is word (base + i).
  typedef logic [CACHE_BLOCK_SIZE-1:0][CACHE_DATA_BITS-1:0] block_t;

  // Server FSM: IDLE accepts requests, WAIT counts down latency, RESP
  // presents the block for exactly one cycle.
  typedef enum logic [1:0] {
    SRV_IDLE = 2'd0,
    SRV_WAIT = 2'd1,
    SRV_RESP = 2'd2
  } server_state_e;

endpackage

// File: rtl/ram_word_array.sv
// Word-addressed storage with one synchronous write port and BLOCK_SIZE
// combinational read ports covering the aligned block at rd_base.
module ram_word_array
  import cache_pkg::*;
#(
  parameter int ADDR_BITS  = CACHE_RAM_ADDRESS_BITS,
  parameter int DATA_BITS  = CACHE_DATA_BITS,
  parameter int BLOCK_BITS = CACHE_BLOCK_BITS,
  localparam int BLOCK_SIZE = 2 ** BLOCK_BITS,
  localparam int DEPTH      = 2 ** ADDR_BITS
) (
  input  logic                                 clk,
  input  logic                                 wr_en,
  input  logic [ADDR_BITS-1:0]                 wr_addr,
  input  logic [DATA_BITS-1:0]                 wr_data,
  input  logic [ADDR_BITS-1:0]                 rd_base,
  output logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] rd_data
);

  // Power-up content is all ones; reset deliberately does not touch storage.
  logic [DATA_BITS-1:0] mem_q [DEPTH] = '{default: '1};

  // Single-word write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Block read ports; rd_base is aligned so base + i never wraps past the top.
  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      rd_data[i] = mem_q[rd_base + ADDR_BITS'(i)];
    end
  end

endmodule

// File: rtl/ram_block_server.sv
// Block-fill RAM server for the cache: single-word writes, aligned block
// reads returned LATENCY cycles after acceptance.
//
// Handshake: a request (read_en and/or write_en) is taken at a rising edge
// only when ready=1 and reset_n=1; while ready=0 requests are dropped, not
// queued. ram_valid is a one-cycle pulse qualifying ram_data and has no
// back-pressure.
module ram_block_server
  import cache_pkg::*;
#(
  parameter int RAM_ADDRESS_BITS = CACHE_RAM_ADDRESS_BITS,
  parameter int DATA_BITS        = CACHE_DATA_BITS,
  parameter int BLOCK_BITS       = CACHE_BLOCK_BITS,
  parameter int LATENCY          = CACHE_LATENCY,
  localparam int BLOCK_SIZE = 2 ** BLOCK_BITS
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [RAM_ADDRESS_BITS-1:0]          address,
  input  logic                                 read_en,
  input  logic [DATA_BITS-1:0]                 write_data,
  input  logic                                 write_en,
  output logic                                 ready,
  output logic                                 ram_valid,
  output logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] ram_data,
  output server_state_e                        state_dbg
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  server_state_e                        state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] block_q, block_d;
  logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] rd_data;
  logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] merged;
  logic [RAM_ADDRESS_BITS-1:0]          block_base;
  logic                                 wr_accept;
  logic                                 rd_accept;

  assign ready      = (state_q == SRV_IDLE);
  assign ram_valid  = (state_q == SRV_RESP);
  assign ram_data   = block_q;
  assign state_dbg  = state_q;

  // Aligning by masking keeps the block inside memory, so no wrap is possible.
  assign block_base = address & ~(RAM_ADDRESS_BITS'(BLOCK_SIZE - 1));
  assign wr_accept  = reset_n && ready && write_en;
  assign rd_accept  = reset_n && ready && read_en;

  ram_word_array #(
    .ADDR_BITS (RAM_ADDRESS_BITS),
    .DATA_BITS (DATA_BITS),
    .BLOCK_BITS(BLOCK_BITS)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_accept),
    .wr_addr(address),
    .wr_data(write_data),
    .rd_base(block_base),
    .rd_data(rd_data)
  );

  // Write-first bypass: a same-edge write lands in the captured block.
  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      merged[i] = rd_data[i];
      if (wr_accept && (address == block_base + RAM_ADDRESS_BITS'(i))) begin
        merged[i] = write_data;
      end
    end
  end

  // Next-state, latency counter and block capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    case (state_q)
      SRV_IDLE: begin
        if (rd_accept) begin
          block_d = merged;
          if (LATENCY == 1) begin
            state_d = SRV_RESP;
          end else begin
            state_d = SRV_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      SRV_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = SRV_RESP;
        end
      end
      SRV_RESP: begin
        state_d = SRV_IDLE;
      end
      default: begin
        state_d = SRV_IDLE;
      end
    endcase
  end

  // State registers; reset drops any pending response and clears the buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= SRV_IDLE;
      cnt_q   <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  end

endmodule

// File: tb/tb_ram_block_server.sv
// Randomized self-checking bench for ram_block_server against a word-array
// reference model; a second instance checks the single-cycle latency build.
module tb_ram_block_server;
  import cache_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 128;
  localparam int LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          read_en = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          write_en = 1'b0;
  logic          ready;
  logic          ram_valid;
  block_t        ram_data;
  server_state_e state_dbg;

  logic          b_reset_n = 1'b0;
  logic [AW-1:0] b_address = '0;
  logic          b_read_en = 1'b0;
  logic          b_write_en = 1'b0;
  logic          b_ready;
  logic          b_ram_valid;
  block_t        b_ram_data;
  server_state_e b_state_dbg;

  ram_block_server #(.LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read_en(read_en),
    .write_data(write_data), .write_en(write_en), .ready(ready),
    .ram_valid(ram_valid), .ram_data(ram_data), .state_dbg(state_dbg)
  );

  ram_block_server #(.LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(b_reset_n), .address(b_address), .read_en(b_read_en),
    .write_data(write_data), .write_en(b_write_en), .ready(b_ready),
    .ram_valid(b_ram_valid), .ram_data(b_ram_data), .state_dbg(b_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] ref_mem [2**AW];
  logic [BW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] ref_block(input logic [AW-1:0] a);
    logic [BW-1:0] r;
    int base;
    base = int'(a) - (int'(a) % 4);
    for (int i = 0; i < 4; i++) r[i*DW +: DW] = ref_mem[base + i];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for the response of a read accepted at the previous edge.
  task automatic wait_resp();
    int k;
    k = 1;
    while (!ram_valid && k <= 20) begin
      chk("busy_ready", ready, 1'b0);
      step();
      k++;
    end
    if (!ram_valid) begin
      chk("resp_timeout", 1'b0, 1'b1);
    end else begin
      chk("latency", k, LAT);
      chk("resp_ready", ready, 1'b0);
      chk("ram_data", ram_data, exp_q.pop_front());
      step();
      chk("valid_pulse", ram_valid, 1'b0);
      chk("ready_back", ready, 1'b1);
    end
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk("ready_idle", ready, 1'b1);
    address    = a;
    read_en    = rd;
    write_en   = wr;
    write_data = d;
    if (wr) ref_mem[a] = d;
    if (rd) exp_q.push_back(ref_block(a));
    step();
    read_en  = 1'b0;
    write_en = 1'b0;
    if (rd) begin
      wait_resp();
    end else begin
      chk("wr_no_valid", ram_valid, 1'b0);
      chk("wr_stays_idle", ready, 1'b1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd_word;
    int op;
    int nvalid;
    logic [BW-1:0] b_exp;

    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '1;

    // Requests during reset must be ignored.
    reset_n = 1'b0;
    address = 10'h005; write_data = 32'h0; write_en = 1'b1; read_en = 1'b1;
    repeat (3) step();
    write_en = 1'b0; read_en = 1'b0;
    reset_n = 1'b1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", ram_valid, 1'b0);
    chk("rst_data", ram_data, '0);
    step();
    chk("rst_no_valid", ram_valid, 1'b0);

    // Power-up block read.
    do_req(1'b1, 1'b0, 10'h005, 32'h0);
    // Write then block read.
    do_req(1'b0, 1'b1, 10'h006, 32'h12345678);
    do_req(1'b1, 1'b0, 10'h004, 32'h0);
    // Same-edge write and read at top block.
    do_req(1'b1, 1'b1, 10'h3FD, 32'hA5A5A5A5);

    // Requests held while busy are dropped.
    address = 10'h010; read_en = 1'b1;
    exp_q.push_back(ref_block(10'h010));
    step();
    address = 10'h011; write_data = 32'hDEADBEEF; write_en = 1'b1; read_en = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 20 && nvalid == 0; k++) begin
      if (ram_valid) nvalid++;
      else step();
    end
    chk("held_valid_seen", nvalid, 1);
    if (nvalid == 1) chk("held_data", ram_data, exp_q.pop_front());
    read_en = 1'b0; write_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ram_valid) nvalid++;
    end
    chk("held_single_valid", nvalid, 1);
    do_req(1'b1, 1'b0, 10'h010, 32'h0);

    // Reset while a read is pending.
    do_req(1'b0, 1'b1, 10'h020, 32'hCAFEBABE);
    address = 10'h020; read_en = 1'b1;
    step();
    read_en = 1'b0;
    reset_n = 1'b0;
    address = 10'h030; write_data = 32'h0; write_en = 1'b1;
    step();
    write_en = 1'b0;
    reset_n = 1'b1;
    chk("midrd_rst_ready", ready, 1'b1);
    chk("midrd_rst_data", ram_data, '0);
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      if (ram_valid) nvalid++;
      step();
    end
    chk("midrd_no_valid", nvalid, 0);
    do_req(1'b1, 1'b0, 10'h020, 32'h0);
    do_req(1'b1, 1'b0, 10'h030, 32'h0);

    // Random mix of writes, reads and combined requests.
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 2);
      ra = ($urandom_range(0, 3) == 0) ? AW'(10'h3FC + $urandom_range(0, 3))
                                       : AW'($urandom_range(0, 31));
      rd_word = $urandom;
      do_req(op != 0, op != 1, ra, rd_word);
      repeat ($urandom_range(0, 2)) step();
    end

    // Single-cycle latency instance.
    b_reset_n = 1'b0;
    step();
    b_reset_n = 1'b1;
    chk("l1_rst_ready", b_ready, 1'b1);
    write_data = 32'h0BADF00D; b_address = 10'h00D; b_write_en = 1'b1;
    step();
    b_write_en = 1'b0;
    chk("l1_wr_no_valid", b_ram_valid, 1'b0);
    b_address = 10'h008; b_read_en = 1'b1;
    step();
    chk("l1_valid_next", b_ram_valid, 1'b1);
    chk("l1_busy", b_ready, 1'b0);
    chk("l1_data0", b_ram_data, {4{32'hFFFFFFFF}});
    b_address = 10'h00C;
    step();
    chk("l1_gap_valid", b_ram_valid, 1'b0);
    chk("l1_gap_ready", b_ready, 1'b1);
    step();
    b_read_en = 1'b0;
    b_exp = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0BADF00D, 32'hFFFFFFFF};
    chk("l1_valid_2", b_ram_valid, 1'b1);
    chk("l1_data1", b_ram_data, b_exp);
    step();
    chk("l1_pulse_end", b_ram_valid, 1'b0);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
